pipeline_hazard_unit: RTL and testbench

//  Central hazard controller for the 5-stage RV32 core: forwarding muxes, load-use interlock,

---
 rtl/pipeline_hazard_unit_pkg.sv | 30 +++
 rtl/pipeline_hazard_unit_fwd_mux.sv | 46 ++++
 rtl/pipeline_hazard_unit.sv | 190 +++++++++++++++++++
 tb/tb_pipeline_hazard_unit.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_unit_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipeline_hazard_unit_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LU_STALL  = 2'd1,
        IMEM_WAIT = 2'd2,
        DMEM_WAIT = 2'd3
    } hz_state_e;

    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_MEM  = 2'd1,
        FWD_WB   = 2'd2
    } fwd_sel_e;

    localparam int unsigned RV_X0 = 0;

    // Per-cycle pipeline control bundle driven by the hazard FSM.
    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_ex;
        logic stall_mem;
        logic flush_id;
        logic flush_ex;
        logic err_timeout;
    } hz_ctrl_t;

endpackage

// File: rtl/pipeline_hazard_unit_fwd_mux.sv
// One EX operand bypass: picks MEM result, then WB result, then the ID/EX register value.
module pipeline_hazard_unit_fwd_mux
    import pipeline_hazard_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 5
) (
    input  logic [RA_W-1:0] rs_i,
    input  logic [RA_W-1:0] mem_rd_i,
    input  logic            mem_we_i,
    input  logic [XLEN-1:0] mem_data_i,
    input  logic [RA_W-1:0] wb_rd_i,
    input  logic            wb_we_i,
    input  logic [XLEN-1:0] wb_data_i,
    input  logic [XLEN-1:0] reg_data_i,
    output logic [XLEN-1:0] op_o
);

    fwd_sel_e sel;
    logic     rs_nz;
    logic     mem_hit;
    logic     wb_hit;

    // x0 is hardwired to zero, so a write targeting it must never be bypassed.
    always_comb begin
        rs_nz   = (rs_i != RA_W'(RV_X0));
        mem_hit = mem_we_i && rs_nz && (mem_rd_i == rs_i);
        wb_hit  = wb_we_i && rs_nz && (wb_rd_i == rs_i);
        sel     = FWD_NONE;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
    end

    always_comb begin
        op_o = reg_data_i;
        case (sel)
            FWD_MEM: op_o = mem_data_i;
            FWD_WB:  op_o = wb_data_i;
            default: op_o = reg_data_i;
        endcase
    end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard controller for the 5-stage RV32 core: operand forwarding, load-use interlock,
// memory-wait stalls with timeout, redirect flush and a stall-cycle performance counter.
module pipeline_hazard_unit
    import pipeline_hazard_unit_pkg::*;
#(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned RA_W        = 5,
    parameter int unsigned LU_BUBBLES  = 1,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [RA_W-1:0]  id_rs1_i,
    input  logic [RA_W-1:0]  id_rs2_i,
    input  logic [RA_W-1:0]  ex_rs1_i,
    input  logic [RA_W-1:0]  ex_rs2_i,
    input  logic [RA_W-1:0]  ex_rd_i,
    input  logic             ex_load_i,
    input  logic             ex_redirect_i,
    input  logic [RA_W-1:0]  mem_rd_i,
    input  logic [RA_W-1:0]  wb_rd_i,
    input  logic             mem_we_i,
    input  logic             wb_we_i,
    input  logic [XLEN-1:0]  mem_data_i,
    input  logic [XLEN-1:0]  wb_data_i,
    input  logic [XLEN-1:0]  ex_opa_i,
    input  logic [XLEN-1:0]  ex_opb_i,
    input  logic             imem_req_i,
    input  logic             imem_valid_i,
    input  logic             dmem_req_i,
    input  logic             dmem_valid_i,
    output logic [XLEN-1:0]  alu_a_o,
    output logic [XLEN-1:0]  alu_b_o,
    output logic             stall_if_o,
    output logic             stall_id_o,
    output logic             stall_ex_o,
    output logic             stall_mem_o,
    output logic             flush_id_o,
    output logic             flush_ex_o,
    output logic             err_timeout_o,
    output logic [CNT_W-1:0] stall_cycles_o
);

    localparam int unsigned BUB_W  = 2;
    localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    hz_state_e         state_q, state_d;
    logic [BUB_W-1:0]  bub_q, bub_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  stall_cnt_q;

    logic [XLEN-1:0]   fwd_a, fwd_b;
    hz_ctrl_t          ctrl, ctrl_g;

    logic              lu_hit;
    logic              dmem_wait, imem_wait;
    logic [WAIT_W-1:0] wait_inc, dmem_cnt, imem_cnt;
    logic              dmem_tmo, imem_tmo;

    pipeline_hazard_unit_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_a (
        .rs_i       (ex_rs1_i),
        .mem_rd_i   (mem_rd_i),
        .mem_we_i   (mem_we_i),
        .mem_data_i (mem_data_i),
        .wb_rd_i    (wb_rd_i),
        .wb_we_i    (wb_we_i),
        .wb_data_i  (wb_data_i),
        .reg_data_i (ex_opa_i),
        .op_o       (fwd_a)
    );

    pipeline_hazard_unit_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_b (
        .rs_i       (ex_rs2_i),
        .mem_rd_i   (mem_rd_i),
        .mem_we_i   (mem_we_i),
        .mem_data_i (mem_data_i),
        .wb_rd_i    (wb_rd_i),
        .wb_we_i    (wb_we_i),
        .wb_data_i  (wb_data_i),
        .reg_data_i (ex_opb_i),
        .op_o       (fwd_b)
    );

    // Hazard detection and wait-age bookkeeping; a wait that continues keeps aging,
    // a fresh wait starts at one (the detecting cycle is the first waiting cycle).
    always_comb begin
        lu_hit    = ex_load_i && (ex_rd_i != RA_W'(RV_X0)) &&
                    ((ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i));
        dmem_wait = dmem_req_i && !dmem_valid_i;
        imem_wait = imem_req_i && !imem_valid_i;
        wait_inc  = (wait_q == '1) ? wait_q : wait_q + WAIT_W'(1);
        dmem_cnt  = (state_q == DMEM_WAIT) ? wait_inc : WAIT_W'(1);
        imem_cnt  = (state_q == IMEM_WAIT) ? wait_inc : WAIT_W'(1);
        dmem_tmo  = (MEM_TIMEOUT != 0) && (32'(dmem_cnt) >= MEM_TIMEOUT);
        imem_tmo  = (MEM_TIMEOUT != 0) && (32'(imem_cnt) >= MEM_TIMEOUT);
    end

    // Next state and stall/flush controls, in priority order: DMEM wait, pending
    // load-use bubbles, redirect, new load-use, IMEM wait.
    always_comb begin
        state_d = state_q;
        bub_d   = bub_q;
        wait_d  = wait_q;
        ctrl    = '0;
        if (dmem_wait) begin
            bub_d = '0;
            if (dmem_tmo) begin
                ctrl.err_timeout = 1'b1;
                state_d          = RUN;
                wait_d           = '0;
            end else begin
                ctrl.stall_if  = 1'b1;
                ctrl.stall_id  = 1'b1;
                ctrl.stall_ex  = 1'b1;
                ctrl.stall_mem = 1'b1;
                state_d        = DMEM_WAIT;
                wait_d         = dmem_cnt;
            end
        end else if (state_q == LU_STALL) begin
            ctrl.stall_if = 1'b1;
            ctrl.stall_id = 1'b1;
            ctrl.flush_ex = 1'b1;
            bub_d         = bub_q - BUB_W'(1);
            if (bub_q <= BUB_W'(1)) begin
                state_d = RUN;
            end
        end else if (ex_redirect_i) begin
            ctrl.flush_id = 1'b1;
            ctrl.flush_ex = 1'b1;
            state_d       = RUN;
        end else if (lu_hit) begin
            ctrl.stall_if = 1'b1;
            ctrl.stall_id = 1'b1;
            ctrl.flush_ex = 1'b1;
            bub_d         = BUB_W'(LU_BUBBLES - 1);
            state_d       = (LU_BUBBLES > 1) ? LU_STALL : RUN;
        end else if (imem_wait) begin
            if (imem_tmo) begin
                ctrl.err_timeout = 1'b1;
                state_d          = RUN;
                wait_d           = '0;
            end else begin
                ctrl.stall_if = 1'b1;
                ctrl.flush_id = 1'b1;
                state_d       = IMEM_WAIT;
                wait_d        = imem_cnt;
            end
        end else begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
            bub_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            bub_q   <= bub_d;
            wait_q  <= wait_d;
        end
    end

    // Saturating count of fetch-stall cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
        end else if (ctrl.stall_if && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        ctrl_g  = rst_ni ? ctrl : '0;
        alu_a_o = rst_ni ? fwd_a : '0;
        alu_b_o = rst_ni ? fwd_b : '0;
    end

    assign stall_if_o     = ctrl_g.stall_if;
    assign stall_id_o     = ctrl_g.stall_id;
    assign stall_ex_o     = ctrl_g.stall_ex;
    assign stall_mem_o    = ctrl_g.stall_mem;
    assign flush_id_o     = ctrl_g.flush_id;
    assign flush_ex_o     = ctrl_g.flush_ex;
    assign err_timeout_o  = ctrl_g.err_timeout;
    assign stall_cycles_o = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Bench for pipeline_hazard_unit: directed hazard scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the hazard rules.
module tb_pipeline_hazard_unit;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned RA_W  = 5;
    localparam int unsigned LUB   = 2;
    localparam int unsigned TMO   = 8;
    localparam int unsigned CNT_W = 6;
    localparam int          CNT_MAX = 63;

    logic             clk = 1'b0;
    logic             rst_ni;
    logic [RA_W-1:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic             ex_load, ex_redirect, mem_we, wb_we;
    logic [XLEN-1:0]  mem_data, wb_data, ex_opa, ex_opb;
    logic             imem_req, imem_valid, dmem_req, dmem_valid;
    logic [XLEN-1:0]  alu_a, alu_b;
    logic             stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, err_timeout;
    logic [CNT_W-1:0] stall_cycles;
    wire  [6:0]       ctrl_v = {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, err_timeout};

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_unit #(
        .XLEN(XLEN), .RA_W(RA_W), .LU_BUBBLES(LUB), .MEM_TIMEOUT(TMO), .CNT_W(CNT_W)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .ex_rs1_i(ex_rs1), .ex_rs2_i(ex_rs2),
        .ex_rd_i(ex_rd), .ex_load_i(ex_load), .ex_redirect_i(ex_redirect),
        .mem_rd_i(mem_rd), .wb_rd_i(wb_rd), .mem_we_i(mem_we), .wb_we_i(wb_we),
        .mem_data_i(mem_data), .wb_data_i(wb_data), .ex_opa_i(ex_opa), .ex_opb_i(ex_opb),
        .imem_req_i(imem_req), .imem_valid_i(imem_valid),
        .dmem_req_i(dmem_req), .dmem_valid_i(dmem_valid),
        .alu_a_o(alu_a), .alu_b_o(alu_b),
        .stall_if_o(stall_if), .stall_id_o(stall_id), .stall_ex_o(stall_ex),
        .stall_mem_o(stall_mem), .flush_id_o(flush_id), .flush_ex_o(flush_ex),
        .err_timeout_o(err_timeout), .stall_cycles_o(stall_cycles)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = '0; id_rs2 = '0; ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0;
        mem_rd = '0; wb_rd = '0; ex_load = 1'b0; ex_redirect = 1'b0;
        mem_we = 1'b0; wb_we = 1'b0; mem_data = '0; wb_data = '0;
        ex_opa = '0; ex_opb = '0; imem_req = 1'b0; imem_valid = 1'b0;
        dmem_req = 1'b0; dmem_valid = 1'b0;
    endtask

    task automatic apply_reset();
        idle();
        rst_ni = 1'b0;
        repeat (2) tick();
        rst_ni = 1'b1;
        tick();
    endtask

    // Bypass selection straight from the forwarding rules.
    function automatic logic [XLEN-1:0] ref_fwd(input logic [RA_W-1:0] rs, input logic [XLEN-1:0] reg_val);
        if (rs != 0 && mem_we && mem_rd == rs) return mem_data;
        if (rs != 0 && wb_we && wb_rd == rs) return wb_data;
        return reg_val;
    endfunction

    task automatic test_reset();
        idle();
        rst_ni = 1'b0;
        ex_load = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; ex_redirect = 1'b1;
        dmem_req = 1'b1; mem_we = 1'b1; mem_rd = 5'd1; ex_rs1 = 5'd1; mem_data = 32'h1234_5678;
        #3;
        checks++;
        if (ctrl_v !== 7'b0 || alu_a !== '0 || stall_cycles !== '0) begin
            errors++;
            $display("FAIL reset_hold: ctrl=%b alu_a=%h cnt=%0d required ctrl=0 alu_a=0 cnt=0", ctrl_v, alu_a, stall_cycles);
        end
        // Enter a data wait, then reset in the middle of it.
        idle();
        rst_ni = 1'b1;
        tick();
        dmem_req = 1'b1;
        tick();
        tick();
        checks++;
        if (ctrl_v !== 7'b1111000) begin
            errors++;
            $display("FAIL reset_prewait: ctrl=%b required 1111000", ctrl_v);
        end
        rst_ni = 1'b0;
        #1;
        checks++;
        if (ctrl_v !== 7'b0 || stall_cycles !== '0) begin
            errors++;
            $display("FAIL reset_midwait: ctrl=%b cnt=%0d required 0/0", ctrl_v, stall_cycles);
        end
        tick();
        idle();
        rst_ni = 1'b1;
        tick();
        #3;
        checks++;
        if (ctrl_v !== 7'b0 || stall_cycles !== '0) begin
            errors++;
            $display("FAIL reset_after: ctrl=%b cnt=%0d required 0/0", ctrl_v, stall_cycles);
        end
        tick();
    endtask

    task automatic test_fwd_priority();
        idle();
        mem_we = 1'b1; mem_rd = 5'd5; mem_data = 32'hAAAA_0001;
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hBBBB_0002;
        ex_rs1 = 5'd5; ex_opa = 32'hCCCC_0003;
        ex_rs2 = 5'd7; ex_opb = 32'hDDDD_0004;
        #3;
        checks++;
        if (alu_a !== 32'hAAAA_0001 || alu_b !== 32'hDDDD_0004) begin
            errors++;
            $display("FAIL fwd_mem_prio: a=%h b=%h required a=aaaa0001 b=dddd0004", alu_a, alu_b);
        end
        mem_we = 1'b0; ex_rs2 = 5'd5;
        #1;
        checks++;
        if (alu_a !== 32'hBBBB_0002 || alu_b !== 32'hBBBB_0002) begin
            errors++;
            $display("FAIL fwd_wb: a=%h b=%h required bbbb0002 both", alu_a, alu_b);
        end
        tick();
    endtask

    task automatic test_fwd_x0();
        idle();
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h0000_DEAD;
        mem_we = 1'b1; mem_rd = 5'd0; mem_data = 32'h0000_BEEF;
        ex_rs1 = 5'd0; ex_opa = 32'h1111_2222;
        ex_rs2 = 5'd0; ex_opb = 32'h3333_4444;
        #3;
        checks++;
        if (alu_a !== 32'h1111_2222 || alu_b !== 32'h3333_4444 || ctrl_v !== 7'b0) begin
            errors++;
            $display("FAIL fwd_x0: a=%h b=%h ctrl=%b required 11112222 33334444 0", alu_a, alu_b, ctrl_v);
        end
        tick();
    endtask

    task automatic test_load_use();
        idle();
        ex_load = 1'b1; ex_rd = 5'd6; id_rs2 = 5'd6;
        #3;
        checks++;
        if (ctrl_v !== 7'b1100010) begin
            errors++;
            $display("FAIL lu_cycle1: ctrl=%b required 1100010", ctrl_v);
        end
        tick();
        ex_load = 1'b0; ex_rd = 5'd0;
        #3;
        checks++;
        if (ctrl_v !== 7'b1100010) begin
            errors++;
            $display("FAIL lu_cycle2: ctrl=%b required 1100010", ctrl_v);
        end
        tick();
        #3;
        checks++;
        if (ctrl_v !== 7'b0 || stall_cycles !== 6'd2) begin
            errors++;
            $display("FAIL lu_release: ctrl=%b cnt=%0d required 0 and 2", ctrl_v, stall_cycles);
        end
        tick();
    endtask

    task automatic test_dmem_wait();
        idle();
        dmem_req = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            dmem_valid = (c == 5);
            #3;
            checks++;
            if (ctrl_v !== ((c == 5) ? 7'b0 : 7'b1111000)) begin
                errors++;
                $display("FAIL dmem_wait_c%0d: ctrl=%b required %b", c, ctrl_v, (c == 5) ? 7'b0 : 7'b1111000);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_redirect_lu();
        idle();
        ex_redirect = 1'b1; ex_load = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9;
        #3;
        checks++;
        if (ctrl_v !== 7'b0000110) begin
            errors++;
            $display("FAIL redirect_lu: ctrl=%b required 0000110", ctrl_v);
        end
        tick();
        idle();
        #3;
        checks++;
        if (ctrl_v !== 7'b0) begin
            errors++;
            $display("FAIL redirect_after: ctrl=%b required 0", ctrl_v);
        end
        tick();
    endtask

    task automatic test_timeout();
        logic [6:0] exp;
        idle();
        dmem_req = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            if (c == 9) dmem_req = 1'b0;
            exp = (c < 8) ? 7'b1111000 : ((c == 8) ? 7'b0000001 : 7'b0);
            #3;
            checks++;
            if (ctrl_v !== exp) begin
                errors++;
                $display("FAIL timeout_c%0d: ctrl=%b required %b", c, ctrl_v, exp);
            end
            tick();
        end
        idle();
    endtask

    task automatic test_random();
        int         m_lu, m_dw, m_iw, m_cnt;
        int         n_lu, n_dw, n_iw, age;
        logic [6:0] e;
        logic [XLEN-1:0] ea, eb;
        apply_reset();
        m_lu = 0; m_dw = 0; m_iw = 0; m_cnt = 0;
        for (int c = 0; c < 800; c++) begin
            id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
            ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
            ex_rd  = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
            wb_rd  = 5'($urandom_range(0, 3));
            mem_we = ($urandom_range(0, 1) == 1); wb_we = ($urandom_range(0, 1) == 1);
            mem_data = $urandom(); wb_data = $urandom(); ex_opa = $urandom(); ex_opb = $urandom();
            ex_load     = ($urandom_range(0, 9) < 3);
            ex_redirect = ($urandom_range(0, 9) < 1);
            imem_req    = ($urandom_range(0, 9) < 5);
            imem_valid  = ($urandom_range(0, 9) < 3);
            dmem_req    = ($urandom_range(0, 9) < 3);
            dmem_valid  = ($urandom_range(0, 9) < 3);
            #3;
            e = '0; n_lu = 0; n_dw = 0; n_iw = 0;
            if (dmem_req && !dmem_valid) begin
                age = m_dw + 1;
                if (age >= TMO) e[0] = 1'b1;
                else begin e[6:3] = 4'b1111; n_dw = age; end
            end else if (m_lu > 0) begin
                e[6] = 1'b1; e[5] = 1'b1; e[1] = 1'b1; n_lu = m_lu - 1;
            end else if (ex_redirect) begin
                e[2] = 1'b1; e[1] = 1'b1;
            end else if (ex_load && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2)) begin
                e[6] = 1'b1; e[5] = 1'b1; e[1] = 1'b1; n_lu = LUB - 1;
            end else if (imem_req && !imem_valid) begin
                age = m_iw + 1;
                if (age >= TMO) e[0] = 1'b1;
                else begin e[6] = 1'b1; e[2] = 1'b1; n_iw = age; end
            end
            ea = ref_fwd(ex_rs1, ex_opa);
            eb = ref_fwd(ex_rs2, ex_opb);
            checks++;
            if (ctrl_v !== e || alu_a !== ea || alu_b !== eb || int'(stall_cycles) != m_cnt) begin
                errors++;
                $display("FAIL rand_c%0d: ctrl=%b a=%h b=%h cnt=%0d required ctrl=%b a=%h b=%h cnt=%0d",
                         c, ctrl_v, alu_a, alu_b, stall_cycles, e, ea, eb, m_cnt);
            end
            tick();
            m_lu = n_lu; m_dw = n_dw; m_iw = n_iw;
            if (e[6] && m_cnt < CNT_MAX) m_cnt++;
        end
        idle();
    endtask

    task automatic test_saturation();
        apply_reset();
        ex_load = 1'b1; ex_rd = 5'd6; id_rs1 = 5'd6;
        repeat (62) tick();
        #3;
        checks++;
        if (stall_cycles !== 6'd62 || stall_if !== 1'b1) begin
            errors++;
            $display("FAIL sat_62: cnt=%0d stall_if=%b required 62 and 1", stall_cycles, stall_if);
        end
        repeat (20) tick();
        #3;
        checks++;
        if (stall_cycles !== 6'd63) begin
            errors++;
            $display("FAIL sat_hold: cnt=%0d required 63", stall_cycles);
        end
        idle();
        tick();
    endtask

    initial begin
        idle();
        rst_ni = 1'b0;
        test_reset();
        test_fwd_priority();
        test_fwd_x0();
        test_load_use();
        test_dmem_wait();
        test_redirect_lu();
        test_timeout();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
